delay_sched: RTL

- Round-robin scheduler that shares one programmable delay timer between NREQ requesters.
- Each requester asks for a delay of its own length. The block grants the timer to one requester at a time, counts that delay, then pulses done to the owner.
- It sits in front of the delay-counter datapath as its sequencer and arbiter.
- It carries embedded safety and liveness properties for formal checking.

---
 rtl/delay_sched_pkg.sv | 20 ++
 rtl/delay_sched_rr_pick.sv | 32 +++
 rtl/delay_sched.sv | 119 +++++++++++
 3 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay_sched round-robin delay-timer scheduler.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned CBITS_DEF   = 13;
    localparam int unsigned MAX_DLY_DEF = 7500;
    localparam int unsigned ID_W_DEF    = $clog2(NREQ_DEF);

    // Owner-id width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, modulo NREQ.
module rr_pick
    import delay_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            valid
);

    int unsigned    idx;
    logic [IDW-1:0] sel;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            sel = idx[IDW-1:0];
            if (!valid && req[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one programmable delay timer among NREQ requesters.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned CBITS   = CBITS_DEF,
    parameter int unsigned MAX_DLY = MAX_DLY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt
);

    localparam int unsigned      IDW   = id_width(NREQ);
    localparam logic [CBITS-1:0] MAX_C = CBITS'(MAX_DLY);

    state_t           state, state_nxt;
    logic [IDW-1:0]   id, rr_ptr, win_id;
    logic             win_valid;
    logic [CBITS-1:0] target, dly_win, dly_clamped;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (win_id),
        .valid  (win_valid)
    );

    assign dly_win     = dly[win_id*CBITS +: CBITS];
    assign dly_clamped = (dly_win > MAX_C) ? MAX_C : dly_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_valid) state_nxt = RUN;
            RUN: begin
                if (!req[id])           state_nxt = IDLE;
                else if (cnt == target) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
        case (state)
            RUN: begin
                gnt[id] = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done[id] = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // An abandoning owner moves rr_ptr just like a completing one, so it loses its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id     <= '0;
            target <= '0;
            cnt    <= '0;
            rr_ptr <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        id     <= win_id;
                        target <= dly_clamped;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (!req[id]) begin
                        cnt    <= '0;
                        rr_ptr <= id;
                    end else if (cnt != target) begin
                        cnt <= cnt + CBITS'(1);
                    end
                end
                DONE: begin
                    rr_ptr <= id;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
    a_done_after_gnt: assert property (@(posedge clk) disable iff (!rst_n) |done |-> $past(|gnt));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= MAX_C);
    a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt || |done));

`ifdef FORMAL
    for (genvar i = 0; i < NREQ; i++) begin : g_live
        a_live: assert property (@(posedge clk)
            ((s_eventually always rst_n) and (always (req[i] |-> (req[i] s_until done[i]))))
            implies (always (req[i] |-> s_eventually done[i])));
    end
`endif

endmodule
